// File: rtl/abr_msg_arb_ctrl.sv
// Message-level arbiter sharing one abr_msg_buffer write port between two requesters.
// Optional round-robin arbitration enabled by defining ABR_MSG_ARB_RR_EN (default: fixed priority, req 0 wins).
module abr_msg_arb_ctrl #(
    parameter int NUM_WR = 4,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic [1:0]                   req_start_i,
    input  logic [2*LEN_W-1:0]           req_len_i,
    input  logic [1:0]                   req_valid_i,
    input  logic [2*NUM_WR*DATA_W-1:0]   req_data_i,
    output logic [1:0]                   req_ready_o,
    output logic [1:0]                   req_grant_o,
    output logic [1:0]                   req_done_o,
    output logic [NUM_WR-1:0]            buf_data_valid_o,
    output logic [NUM_WR*DATA_W-1:0]     buf_data_o,
    input  logic                         buf_full_i,
    output logic                         buf_flush_o,
    input  logic                         buf_valid0_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int              BEAT_W = NUM_WR * DATA_W;
    localparam logic [LEN_W-1:0] LANES = LEN_W'(NUM_WR);

    logic [1:0]        state;
    logic [1:0]        pending;
    logic [1:0]        grant;
    logic              gidx;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  len_q [2];
    logic              win;
    logic              accept;
    logic [LEN_W-1:0]  n_lanes;
    logic [BEAT_W-1:0] beat;

`ifdef ABR_MSG_ARB_RR_EN
    logic rr_ptr;
    always_comb win = pending[rr_ptr] ? rr_ptr : ~rr_ptr;
`else
    always_comb win = ~pending[0];
`endif

    assign beat    = gidx ? req_data_i[2*BEAT_W-1:BEAT_W] : req_data_i[BEAT_W-1:0];
    assign accept  = (state == ST_STREAM) & req_valid_i[gidx] & ~buf_full_i;
    assign n_lanes = (remaining < LANES) ? remaining : LANES;

    assign req_grant_o = grant;
    assign buf_flush_o = (state == ST_FLUSH);
    assign req_ready_o = (state == ST_STREAM && !buf_full_i) ? grant : '0;
    assign req_done_o  = (state == ST_DONE) ? (2'b01 << gidx) : '0;

    // Lanes past the message tail are dropped and driven as zero.
    always_comb begin
        buf_data_valid_o = '0;
        buf_data_o       = '0;
        if (accept) begin
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (LEN_W'(k) < n_lanes) begin
                    buf_data_valid_o[k]           = 1'b1;
                    buf_data_o[k*DATA_W +: DATA_W] = beat[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= ST_IDLE;
            pending   <= '0;
            grant     <= '0;
            gidx      <= 1'b0;
            remaining <= '0;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
`ifdef ABR_MSG_ARB_RR_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (req_start_i[i] && !pending[i] && !grant[i]) begin
                    pending[i] <= 1'b1;
                    len_q[i]   <= req_len_i[i*LEN_W +: LEN_W];
                end
            end
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        gidx         <= win;
                        grant        <= 2'b01 << win;
                        remaining    <= len_q[win];
                        pending[win] <= 1'b0;
                        state        <= (len_q[win] == '0) ? ST_FLUSH : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        remaining <= remaining - n_lanes;
                        if (remaining == n_lanes) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!buf_valid0_i) begin
                        grant <= '0;
                        state <= ST_DONE;
                    end
                end
                default: begin
`ifdef ABR_MSG_ARB_RR_EN
                    rr_ptr <= ~gidx;
`endif
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abr_msg_arb_ctrl.sv
// Self-checking bench for abr_msg_arb_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level requester/message model.
module tb_abr_msg_arb_ctrl;

    localparam int NW = 4;
    localparam int DW = 32;
    localparam int LW = 16;

    logic               clk = 1'b0;
    logic               rst_b;
    logic [1:0]         req_start;
    logic [2*LW-1:0]    req_len;
    logic [1:0]         req_valid;
    logic [2*NW*DW-1:0] req_data;
    logic [1:0]         req_ready;
    logic [1:0]         req_grant;
    logic [1:0]         req_done;
    logic [NW-1:0]      buf_data_valid;
    logic [NW*DW-1:0]   buf_data;
    logic               buf_full;
    logic               buf_flush;
    logic               buf_valid0;

    abr_msg_arb_ctrl #(.NUM_WR(NW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .req_start_i      (req_start),
        .req_len_i        (req_len),
        .req_valid_i      (req_valid),
        .req_data_i       (req_data),
        .req_ready_o      (req_ready),
        .req_grant_o      (req_grant),
        .req_done_o       (req_done),
        .buf_data_valid_o (buf_data_valid),
        .buf_data_o       (buf_data),
        .buf_full_i       (buf_full),
        .buf_flush_o      (buf_flush),
        .buf_valid0_i     (buf_valid0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: message ownership tracked as requester index and words left.
    int          owner;
    int          done_idx;
    int          left;
    bit          flushing;
    int          beat_no;
    bit          pend [2];
    int          plen [2];
    int          rr;
    int unsigned words [2][64];
    logic [1:0]  prev_grant;
    logic [1:0]  gq [$];

    task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic void model_clear();
        owner = -1; done_idx = -1; left = 0; flushing = 0; beat_no = 0; rr = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0;
            plen[i] = 0;
        end
    endfunction

    function automatic int pick();
`ifdef ABR_MSG_ARB_RR_EN
        return pend[rr] ? rr : 1 - rr;
`else
        return pend[0] ? 0 : 1;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, 256'(req_ready), '0);
        check_val({tag, "_grant"}, 256'(req_grant), '0);
        check_val({tag, "_done"},  256'(req_done), '0);
        check_val({tag, "_stb"},   256'(buf_data_valid), '0);
        check_val({tag, "_data"},  256'(buf_data), '0);
        check_val({tag, "_flush"}, 256'(buf_flush), '0);
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance the model.
    task automatic eval();
        bit           streaming, acc;
        int           n;
        logic [1:0]   e_grant, e_ready, e_done;
        logic [NW-1:0] e_stb;
        logic [NW*DW-1:0] e_data;
        bit           op [2];
        int           oo, w;

        streaming = (owner >= 0) && !flushing;
        acc       = streaming && req_valid[owner] && !buf_full;
        n         = (left < NW) ? left : NW;
        e_grant   = (owner >= 0) ? 2'(1 << owner) : 2'b00;
        e_ready   = (streaming && !buf_full) ? e_grant : 2'b00;
        e_done    = (done_idx >= 0) ? 2'(1 << done_idx) : 2'b00;
        e_stb     = acc ? NW'((1 << n) - 1) : '0;
        e_data    = '0;
        if (acc)
            for (int k = 0; k < n; k++) e_data[k*DW +: DW] = words[owner][4*beat_no + k];

        check_val("grant", 256'(req_grant), 256'(e_grant));
        check_val("ready", 256'(req_ready), 256'(e_ready));
        check_val("done",  256'(req_done), 256'(e_done));
        check_val("strobe", 256'(buf_data_valid), 256'(e_stb));
        check_val("data",  256'(buf_data), 256'(e_data));
        check_val("flush", 256'(buf_flush), 256'((owner >= 0) && flushing));

        if (req_grant != 2'b00 && prev_grant == 2'b00) gq.push_back(req_grant);
        prev_grant = req_grant;

        op[0] = pend[0]; op[1] = pend[1]; oo = owner;
        if (done_idx >= 0) begin
            rr = 1 - done_idx;
            done_idx = -1;
        end else if (owner < 0) begin
            if (op[0] || op[1]) begin
                w = pick();
                owner = w; left = plen[w]; pend[w] = 0;
                flushing = (left == 0); beat_no = 0;
            end
        end else if (!flushing) begin
            if (acc) begin
                left -= n;
                beat_no++;
                if (left == 0) flushing = 1;
            end
        end else if (!buf_valid0) begin
            done_idx = owner; owner = -1; flushing = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (req_start[i] && !op[i] && oo != i) begin
                pend[i] = 1;
                plen[i] = int'(req_len[i*LW +: LW]);
                for (int j = 0; j < 64; j++) words[i][j] = $urandom;
            end
        end
    endtask

    task automatic drive(input logic [1:0] st, input int l0, input int l1,
                         input bit full, input bit v0, input logic [1:0] vld);
        req_start  = st;
        req_len    = {16'(l1), 16'(l0)};
        buf_full   = full;
        buf_valid0 = v0;
        req_valid  = vld;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NW; k++)
                req_data[(i*NW + k)*DW +: DW] = (owner == i && !flushing) ?
                    words[i][4*beat_no + k] : $urandom;
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent [2];
        logic [1:0] st;
        logic [1:0] exp_order [6];

        model_clear();
        prev_grant = '0;
        rst_b = 1'b0;
        req_start = '0; req_len = '0; req_valid = '0; req_data = '0;
        buf_full = 1'b0; buf_valid0 = 1'b0;
        #2;
        check_all_zero("reset");
        #10;
        rst_b = 1'b1;
        @(posedge clk); #1;

        // req0 len=8, flush held while buffer non-empty
        drive(2'b01, 8, 0, 0, 1, 2'b01);
        for (int c = 0; c < 8; c++) drive(2'b00, 0, 0, 0, c < 5, 2'b01);
        // req1 len=6: full beat then 2-lane tail
        drive(2'b10, 0, 6, 0, 0, 2'b10);
        for (int c = 0; c < 7; c++) drive(2'b00, 0, 0, 0, 0, 2'b10);
        // zero-length message
        drive(2'b01, 0, 0, 0, 0, 2'b11);
        for (int c = 0; c < 5; c++) drive(2'b00, 0, 0, 0, 0, 2'b11);
        // buffer full for 3 cycles mid-message
        drive(2'b10, 0, 12, 0, 0, 2'b11);
        for (int c = 0; c < 10; c++) drive(2'b00, 0, 0, c >= 2 && c < 5, 0, 2'b11);

        // both requesters, 3 messages each of len 4, restarting as soon as allowed
        gq.delete();
        sent[0] = 0; sent[1] = 0;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < 2; i++) begin
                st[i] = (sent[i] < 3) && !pend[i] && owner != i;
                if (st[i]) sent[i]++;
            end
            drive(st, 4, 4, 0, 0, 2'b11);
        end
`ifdef ABR_MSG_ARB_RR_EN
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
`endif
        check_val("order_count", 256'(gq.size()), 256'(6));
        for (int j = 0; j < 6; j++)
            check_val($sformatf("order_%0d", j), 256'((j < gq.size()) ? gq[j] : 2'bxx),
                      256'(exp_order[j]));

        // async reset while streaming with the other requester pending
        drive(2'b01, 12, 0, 0, 0, 2'b00);
        drive(2'b10, 0, 4, 0, 0, 2'b00);
        drive(2'b00, 0, 0, 0, 0, 2'b01);
        #2;
        rst_b = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_clear();
        prev_grant = '0;
        #3;
        rst_b = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) drive(2'b00, 0, 0, 0, 0, 2'b11);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            st[0] = ($urandom_range(0, 9) == 0);
            st[1] = ($urandom_range(0, 9) == 0);
            drive(st, $urandom_range(0, 20), $urandom_range(0, 20),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                  {$urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
